// File: rtl/sr_pulse_ctrl.sv
// Button conditioning for the SR latch: sync, debounce, edge detect, then a pulse FSM that sends mutually exclusive s/r pulses with reset priority.
// Optional build macro SR_REDUNDANT_SUPPRESS_EN drops commands that would not change the latch state (q_fb).
module sr_pulse_ctrl #(
  parameter int unsigned DB_CNT  = 4,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned PW_W    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set_raw,
  input  logic btn_rst_raw,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic db_set,
  output logic db_rst
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);
  localparam logic [PW_W-1:0]  PW_MAX  = PW_W'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

  // Channel index 0 is SET, index 1 is RESET.
  logic [1:0]       raw, sync1, sync2, lvl, req;
  logic [CNT_W-1:0] cnt [2];
  logic             pend_s, pend_r;
  logic             want_s, want_r, pass_s, pass_r, clr_s, clr_r;
  logic [PW_W-1:0]  pw, pw_next;
  state_t           state, state_next;

  assign raw    = {btn_rst_raw, btn_set_raw};
  assign db_set = lvl[0];
  assign db_rst = lvl[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: level follows the synchronised line only after DB_CNT stable cycles; req marks the 0->1 change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl    <= '0;
      req    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        req[i] <= 1'b0;
        if (sync2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else begin
          lvl[i] <= sync2[i];
          cnt[i] <= '0;
          req[i] <= sync2[i];
        end
      end
    end
  end

`ifdef SR_REDUNDANT_SUPPRESS_EN
  logic q_meta, q_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      q_meta <= q_fb;
      q_sync <= q_meta;
    end
  end

  assign pass_s = ~q_sync;
  assign pass_r = q_sync;
`else
  logic unused_q_fb;

  assign unused_q_fb = q_fb;
  assign pass_s      = 1'b1;
  assign pass_r      = 1'b1;
`endif

  assign want_s = pend_s | req[0];
  assign want_r = pend_r | req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pw     <= '0;
      pend_s <= 1'b0;
      pend_r <= 1'b0;
      s      <= 1'b0;
      r      <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_next;
      pw     <= pw_next;
      pend_s <= want_s & ~clr_s;
      pend_r <= want_r & ~clr_r;
      s      <= (state_next == PULSE_S);
      r      <= (state_next == PULSE_R);
      busy   <= (state_next != IDLE);
    end
  end

  // Reset wins in IDLE; a SET waiting behind an issued RESET stays pending.
  always_comb begin
    state_next = state;
    pw_next    = pw;
    clr_s      = 1'b0;
    clr_r      = 1'b0;
    case (state)
      IDLE: begin
        pw_next = '0;
        if (want_r && pass_r) begin
          state_next = PULSE_R;
          clr_r      = 1'b1;
        end else begin
          clr_r = want_r;
          if (want_s) begin
            clr_s = 1'b1;
            if (pass_s) state_next = PULSE_S;
          end
        end
      end
      PULSE_S, PULSE_R: begin
        if (pw == PW_MAX) begin
          state_next = GAP;
          pw_next    = '0;
        end else begin
          pw_next = pw + PW_W'(1);
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
